dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported `data_memory`. It shares the memory between the pipeline MEM stage (port 0) and a loader/DMA engine (port 1), which can issue locked bursts. Port 0 has fixed priority with a starvation guard for port 1. The block stalls the pipeline whenever port 0 does not own the memory.

## Interface
- `AW`, 32, address width (byte addresses)
- `DW`, 32, data width
- `LENW`, 4, burst length field width (beats = `p1_len`+1, max 16)
- `STARVE_LIMIT`, 4, consecutive port-0 wins tolerated while port 1 waits
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `p0_req`, `p0_we`  in  1  MEM-stage access request / write enable
- `p0_addr`  in  AW  MEM-stage address
- `p0_wdata`  in  DW  MEM-stage write data
- `p0_rdata`  out  DW  read data; combinational from `mem_rdata`
- `p0_stall`  out  1  `p0_req` and port 0 not granted this cycle
- `p1_req`, `p1_we`  in  1  burst request / direction
- `p1_addr`  in  AW  burst start address
- `p1_len`  in  LENW  beats-1
- `p1_wdata`  in  DW  write data for the current beat
- `p1_wready`  out  1  current write beat consumed `p1_wdata`
- `p1_rvalid`  out  1  registered read beat valid
- `p1_rdata`  out  DW  registered read data
- `p1_done`  out  1  one-cycle pulse after the last beat
- `mem_addr`  out  AW  to `data_memory.address`
- `mem_wdata`  out  DW  to `data_memory.wdata`
- `mem_we`  out  1  to `data_memory.write_control`
- `mem_rdata`  in  DW  from `data_memory.mem_data`

## Operation
- Memory model: combinational read from `mem_addr`; write on posedge `clk` when `mem_we`=1.
- FSM states: `IDLE` and `BURST`.
- `IDLE` arbitration each cycle:
  - Only `p0_req`: port 0 wins.
  - Only `p1_req`: port 1 wins.
  - Both: port 0 wins, unless `starve_cnt` == `STARVE_LIMIT`, in which case port 1 wins.
- Port 0 grant:
  - `mem_*` driven from `p0_*`.
  - `p0_rdata` = `mem_rdata` in the same cycle.
  - `p0_stall`=0.
- Port 1 grant in `IDLE`:
  - This cycle executes beat 0 from `p1_addr`/`p1_we`/`p1_wdata`.
  - Latch `addr`=`p1_addr`+4, `we`=`p1_we`, `remaining`=`p1_len`.
  - If `p1_len`==0, stay in `IDLE`; otherwise go to `BURST`.
- `BURST`:
  - Each cycle drives `mem_addr`=latched `addr` and `mem_we`=latched `we`.
  - `addr` += 4, wrapping modulo 2^AW. `remaining` -= 1.
  - Return to `IDLE` on the beat where `remaining`==1 before the decrement, i.e. the last beat.
  - `p1_req` and its fields are ignored while in `BURST`.
- `p1_wready` = 1 on every port-1 write beat; `p1_wdata` is sampled live each beat.
- Starvation counter `starve_cnt`:
  - Increments when port 0 wins while `p1_req`=1.
  - Clears on any port-1 grant, and when `p1_req`=0.
  - Saturates at `STARVE_LIMIT`.
- `p0_stall`=1 whenever `p0_req`=1 and port 1 owns the memory, including every `BURST` cycle.
- No request: `mem_we`=0; `mem_addr` and `mem_wdata` hold their last driven values.
- Reset mid-burst: the burst is aborted. No `p1_done` is issued and beats that already wrote are not rolled back.

## Timing
- Reset values:
  - state `IDLE`, `starve_cnt`=0, `remaining`=0, latched `addr`=0.
  - `p1_rvalid`=0, `p1_rdata`=0, `p1_done`=0, `p1_wready`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `p0_stall`=0.
- Port 0: zero-latency read and write; no stall when uncontended.
- Port 1 read beat in cycle N: `p1_rvalid` and `p1_rdata` appear in N+1.
- `p1_done` pulses in the cycle after the last beat, coinciding with the last `p1_rvalid` for reads.
- A burst of L+1 beats occupies the memory for exactly L+1 consecutive cycles.
- A new arbitration can happen in the cycle `p1_done` is high.
- Worst-case pipeline stall per port-1 grant is 2^LENW cycles.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (`IDLE`, `BURST`);
  - `ADDR_STEP`=4;
  - default `STARVE_LIMIT`.
- Sub-module `dmem_starve_ctr`: saturating counter with inc/clr inputs and an `at_limit` output.
- Everything else stays in `dmem_arbiter`.

## Test plan
- Reset released, `p0_req`=1, `p0_we`=1, `addr`=0, `wdata`=56, then a read of `addr` 0 -> `p0_rdata`=56 in the read cycle, `p0_stall`=0 throughout.
- `p1` write burst: `addr`=20, `len`=3, `wdata` 1..4 -> `p1_wready` high for 4 cycles at `addr` 20, 24, 28, 32. `p1_done` pulses in cycle 5. Port-0 reads then return 1..4.
- `p1` read burst: `addr`=20, `len`=3 -> `p1_rvalid` on 4 consecutive cycles with data 1..4. `p1_done` coincides with the 4th.
- `p0_req` and `p1_req` held together, `STARVE_LIMIT`=4 -> port 0 wins 4 cycles, port 1 wins on the 5th, `p0_stall`=1 only in that cycle (`len`=0).
- Burst start at `addr` 0xFFFF_FFFC, `len`=1 -> second beat `mem_addr`=0x0000_0000.
- `rst` asserted in the 2nd beat of a 4-beat burst -> outputs return to reset values immediately, no `p1_done`, FSM in `IDLE` after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned ADDR_STEP            = 4;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of port-0 wins while port 1 waits; at_limit is registered.
module dmem_starve_ctr #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CW    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over increment; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      at_limit <= (LIMIT == 0);
    end else begin
      cnt_q    <= cnt_d;
      at_limit <= (cnt_d == CW'(LIMIT));
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (port 0, priority)
// and a burst-capable loader/DMA engine (port 1) with a starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned LENW         = 4,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [AW-1:0]   p0_addr,
  input  logic [DW-1:0]   p0_wdata,
  output logic [DW-1:0]   p0_rdata,
  output logic            p0_stall,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [AW-1:0]   p1_addr,
  input  logic [LENW-1:0] p1_len,
  input  logic [DW-1:0]   p1_wdata,
  output logic            p1_wready,
  output logic            p1_rvalid,
  output logic [DW-1:0]   p1_rdata,
  output logic            p1_done,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_e      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic            we_q, we_d;
  logic [AW-1:0]   hold_addr_q;
  logic [DW-1:0]   hold_wdata_q;

  logic            gnt0, gnt1, last_beat, beat_we;
  logic [AW-1:0]   drv_addr;
  logic [DW-1:0]   drv_wdata;
  logic            at_limit;

  dmem_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CW    (CW)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (gnt0 && p1_req),
    .clr      (gnt1 || !p1_req),
    .at_limit (at_limit)
  );

  // Arbitration, burst sequencing and memory-port steering.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    we_d      = we_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    last_beat = 1'b0;
    beat_we   = 1'b0;
    drv_addr  = hold_addr_q;
    drv_wdata = hold_wdata_q;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (p0_req && !(p1_req && at_limit)) begin
            gnt0      = 1'b1;
            drv_addr  = p0_addr;
            drv_wdata = p0_wdata;
            beat_we   = p0_we;
          end else if (p1_req) begin
            gnt1      = 1'b1;
            drv_addr  = p1_addr;
            drv_wdata = p1_wdata;
            beat_we   = p1_we;
            addr_d    = p1_addr + AW'(ADDR_STEP);
            we_d      = p1_we;
            rem_d     = p1_len;
            if (p1_len == '0) begin
              last_beat = 1'b1;
            end else begin
              state_d = BURST;
            end
          end
        end
        BURST: begin
          gnt1      = 1'b1;
          drv_addr  = addr_q;
          drv_wdata = p1_wdata;
          beat_we   = we_q;
          addr_d    = addr_q + AW'(ADDR_STEP);
          rem_d     = rem_q - LENW'(1);
          if (rem_q == LENW'(1)) begin
            last_beat = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_addr  = drv_addr;
  assign mem_wdata = drv_wdata;
  assign mem_we    = beat_we;
  assign p0_rdata  = mem_rdata;
  assign p0_stall  = p0_req && gnt1;
  assign p1_wready = gnt1 && beat_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst context, held memory-port values and registered port-1 responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      rem_q        <= '0;
      we_q         <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      p1_rvalid    <= 1'b0;
      p1_rdata     <= '0;
      p1_done      <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      we_q      <= we_d;
      p1_rvalid <= gnt1 && !beat_we;
      p1_done   <= last_beat;
      if (gnt0 || gnt1) begin
        hold_addr_q  <= drv_addr;
        hold_wdata_q <= drv_wdata;
      end
      if (gnt1 && !beat_we) begin
        p1_rdata <= mem_rdata;
      end
    end
  end

endmodule
